sym_packer_2to8: RTL

Downstream consumer of the 2-bit selector-mux datapath. It collects a stream of 2-bit symbols into 8-bit words, four symbols per word, and presents each word on a registered valid/ready output. A flush request emits a partial word with its symbol count. The block turns the per-cycle 2-bit mux output into byte-wide traffic for later stages.

---
 rtl/pack_pkg.sv | 22 ++
 rtl/pack_out_reg.sv | 79 +++++++
 rtl/sym_packer_2to8.sv | 110 +++++++++++
 3 files changed

// File: rtl/pack_pkg.sv
// Shared constants, types and helpers for the 2-bit symbol to 8-bit word packer.
// The optional parity output is controlled by the PACK_PARITY_EN macro.
package pack_pkg;

    // Symbol width in bits.
    localparam int SYM_W  = 32'd2;
    // Symbols per output word.
    localparam int SYMS   = 32'd4;
    // Packed word width.
    localparam int WORD_W = SYM_W * SYMS;
    // Width of the symbol-count field presented with each word (1..4).
    localparam int LEN_W  = 32'd3;

    // Fill count of the accumulator: 0..3 symbols waiting.
    typedef logic [1:0] fill_cnt_t;

    // Even parity over a full word: XOR of all bits, padding included.
    function automatic logic word_parity(input logic [WORD_W-1:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/pack_out_reg.sv
// Output holding register of the packer: valid/ready handshake, word,
// symbol count and (with PACK_PARITY_EN) the parity bit of the word.
// A load is only requested by the parent when the register is free or
// being drained in the same cycle, so a held word is never overwritten.
module pack_out_reg
    import pack_pkg::*;
#(
    parameter int W = pack_pkg::WORD_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [W-1:0]     data_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic             out_ready_i,
    output logic             out_valid_o,
    output logic [W-1:0]     out_data_o,
`ifdef PACK_PARITY_EN
    output logic             out_parity_o,
`endif
    output logic [LEN_W-1:0] out_len_o
);

    logic             valid_q, valid_d;
    logic [W-1:0]     data_q,  data_d;
    logic [LEN_W-1:0] len_q,   len_d;
`ifdef PACK_PARITY_EN
    logic             parity_q, parity_d;
`endif

    // Next-state of the holding register: load a new word, drop valid on drain, else hold.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        len_d   = len_q;
`ifdef PACK_PARITY_EN
        parity_d = parity_q;
`endif
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
            len_d   = len_i;
`ifdef PACK_PARITY_EN
            parity_d = word_parity(data_i);
`endif
        end else if (valid_q && out_ready_i) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Holding register state; reset discards any held word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            len_q   <= '0;
`ifdef PACK_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            len_q   <= len_d;
`ifdef PACK_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;
    assign out_len_o   = len_q;
`ifdef PACK_PARITY_EN
    assign out_parity_o = parity_q;
`endif

endmodule

// File: rtl/sym_packer_2to8.sv
// Packs a stream of 2-bit symbols into 8-bit words, first symbol in bits [1:0].
// A flush emits a partially filled word, zero padded, with its symbol count.
// Defining PACK_PARITY_EN adds the registered even-parity output out_parity.
module sym_packer_2to8 #(
    parameter int SYM_W = pack_pkg::SYM_W,
    parameter int SYMS  = pack_pkg::SYMS
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic [SYM_W-1:0]        in_data,
    output logic                    in_ready,
    input  logic                    flush,
    output logic                    out_valid,
    output logic [SYM_W*SYMS-1:0]   out_data,
    output logic [2:0]              out_len,
`ifdef PACK_PARITY_EN
    output logic                    out_parity,
`endif
    input  logic                    out_ready
);
    import pack_pkg::*;

    localparam int        W    = SYM_W * SYMS;
    localparam fill_cnt_t LAST = fill_cnt_t'(SYMS - 1);

    // Accumulator holds the symbols of the word being filled; slots at and
    // above the fill count are always zero, which gives the flush padding.
    logic [W-1:0]     acc_q, acc_d;
    fill_cnt_t        cnt_q, cnt_d;

    logic             out_free_s;
    logic             accept_s;
    logic [W-1:0]     image_s;
    logic             load_s;
    logic [LEN_W-1:0] load_len_s;

    // The output register can take a word when it is empty or being drained now.
    assign out_free_s = !out_valid || out_ready;
    assign in_ready   = !reset && out_free_s;
    assign accept_s   = in_valid && in_ready;

    // Word image with the incoming symbol placed at the current fill position.
    always_comb begin
        image_s = acc_q;
        if (accept_s) begin
            image_s[cnt_q*SYM_W +: SYM_W] = in_data;
        end else begin
            image_s = acc_q;
        end
    end

    // Fill/emit decision: complete word, flush with or without a symbol, or keep filling.
    always_comb begin
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        load_s     = 1'b0;
        load_len_s = 3'd0;
        if (accept_s) begin
            if ((cnt_q == LAST) || flush) begin
                // Symbol packed first; a full word wins over the flush.
                load_s     = 1'b1;
                load_len_s = {1'b0, cnt_q} + 3'd1;
                acc_d      = '0;
                cnt_d      = 2'd0;
            end else begin
                acc_d = image_s;
                cnt_d = cnt_q + 2'd1;
            end
        end else if (flush && in_ready && (cnt_q != 2'd0)) begin
            // Flush of a partial word; ignored while the output is held.
            load_s     = 1'b1;
            load_len_s = {1'b0, cnt_q};
            acc_d      = '0;
            cnt_d      = 2'd0;
        end else begin
            acc_d = acc_q;
            cnt_d = cnt_q;
        end
    end

    // Accumulator and fill counter; reset discards the partial word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
            cnt_q <= 2'd0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    pack_out_reg #(
        .W (W)
    ) u_out_reg (
        .clk          (clk),
        .reset        (reset),
        .load_i       (load_s),
        .data_i       (image_s),
        .len_i        (load_len_s),
        .out_ready_i  (out_ready),
        .out_valid_o  (out_valid),
        .out_data_o   (out_data),
`ifdef PACK_PARITY_EN
        .out_parity_o (out_parity),
`endif
        .out_len_o    (out_len)
    );

endmodule
